// File: rtl/seq_chunk_adder_if.sv
// Operand/result bundle for seq_chunk_adder: start/busy/done handshake plus operand and result buses.
// The sub request member exists only when SEQ_CHUNK_ADDER_SUB_EN is defined.
interface seq_chunk_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

`ifdef SEQ_CHUNK_ADDER_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout, overflow);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout, overflow);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout, overflow);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, overflow);
`endif
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: WIDTH-bit operands summed CHUNK bits per clock with a registered carry.
// Optional subtract mode (a - b) is enabled by defining SEQ_CHUNK_ADDER_SUB_EN.
//
//   state  | meaning
//   S_IDLE | waiting for start
//   S_RUN  | adding one chunk per cycle, busy=1
//   S_DONE | result valid for one cycle (done=1); start re-enters S_RUN directly
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic              clk,
  input logic              rst,
  seq_chunk_adder_if.slave bus
);
  localparam int K = WIDTH / CHUNK;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK with 1 <= CHUNK <= WIDTH");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] s_chunk;
  logic             c_chunk;
  logic             msb_cin;

`ifdef SEQ_CHUNK_ADDER_SUB_EN
  // a - b == a + ~b + 1; cin is ignored while subtracting
  assign b_in = bus.sub ? ~bus.b : bus.b;
  assign c_in = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_in = bus.b;
  assign c_in = bus.cin;
`endif

  assign accept = bus.start && (state == S_IDLE || state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (bus.start) state_nxt = S_RUN;
      S_RUN:   if (cnt == LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = bus.start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == S_RUN);
    bus.done = (state == S_DONE);
  end

  always_comb begin
    a_chunk = a_r[int'(cnt)*CHUNK +: CHUNK];
    b_chunk = b_r[int'(cnt)*CHUNK +: CHUNK];
    {c_chunk, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
    // carry into the MSB recovered from the MSB sum bit; meaningful on the last chunk only
    msb_cin = a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ s_chunk[CHUNK-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      carry  <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (accept) begin
      a_r   <= bus.a;
      b_r   <= b_in;
      carry <= c_in;
      cnt   <= '0;
      sum_r <= '0;
    end else if (state == S_RUN) begin
      sum_r[int'(cnt)*CHUNK +: CHUNK] <= s_chunk;
      carry <= c_chunk;
      cnt   <= cnt + CW'(1);
      if (cnt == LAST) begin
        cout_r <= c_chunk;
        ovf_r  <= msb_cin ^ c_chunk;
      end
    end
  end

  assign bus.sum      = sum_r;
  assign bus.cout     = cout_r;
  assign bus.overflow = ovf_r;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Randomized self-checking bench for seq_chunk_adder (16/4 cycle model plus an 8/1 bit-serial instance).
module tb_seq_chunk_adder;
  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  seq_chunk_adder_if #(.WIDTH(16)) bus16 ();
  seq_chunk_adder_if #(.WIDTH(8))  bus8 ();

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  seq_chunk_adder #(.WIDTH(8),  .CHUNK(1)) dut8  (.clk(clk), .rst(rst), .bus(bus8));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-word reference: unsigned modulo sum, carry from range check, overflow from signed range.
  function automatic void ref_add(input int w, input logic [15:0] a, input logic [15:0] b,
                                  input logic c, input logic s,
                                  output logic [15:0] sum, output logic co, output logic ov);
    longint m, ua, ub, sa, sb, tot, st;
    m  = longint'(1) << w;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (s) begin
      tot = ua + (m - ub);
      st  = sa - sb;
    end else begin
      tot = ua + ub + longint'(c);
      st  = sa + sb + longint'(c);
    end
    sum = 16'(tot % m);
    co  = (tot >= m);
    ov  = (st >= m / 2) || (st < -(m / 2));
  endfunction

  // Transaction-level model for the 16/4 instance: result appears K=4 edges after acceptance.
  logic        m_live = 1'b0;
  logic        m_busy, m_done, m_cout, m_ovf;
  logic [15:0] m_sum;
  int          m_left;
  logic [15:0] p_sum;
  logic        p_co, p_ov, s_in;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_sum = 0; m_cout = 0; m_ovf = 0; m_left = 0; m_live = 1;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0; m_done = 1; m_sum = p_sum; m_cout = p_co; m_ovf = p_ov;
      end
    end else begin
      m_done = 0;
      if (bus16.start) begin
`ifdef SEQ_CHUNK_ADDER_SUB_EN
        s_in = bus16.sub;
`else
        s_in = 1'b0;
`endif
        ref_add(16, bus16.a, bus16.b, bus16.cin, s_in, p_sum, p_co, p_ov);
        m_left = 4; m_busy = 1; m_sum = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("busy", 32'(bus16.busy), 32'(m_busy));
      chk("done", 32'(bus16.done), 32'(m_done));
      chk("cout", 32'(bus16.cout), 32'(m_cout));
      chk("overflow", 32'(bus16.overflow), 32'(m_ovf));
      if (!m_busy) chk("sum", 32'(bus16.sum), 32'(m_sum));
    end
  end

  task automatic go16(input logic [15:0] a, input logic [15:0] b, input logic c, input logic hold);
    bus16.start = 1'b1; bus16.a = a; bus16.b = b; bus16.cin = c;
    @(negedge clk);
    bus16.start = hold;
    bus16.a = 16'($urandom); bus16.b = 16'($urandom); bus16.cin = 1'($urandom);
  endtask

  task automatic wait16(input int exp_lat);
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus16.done && n < 40);
    chk("latency16", 32'(n), 32'(exp_lat));
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c, output int lat);
    bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.cin = c;
    @(negedge clk);
    bus8.start = 1'b0; bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus8.done && lat < 40);
  endtask

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 5))
      0: return 16'hFFFF;
      1: return 16'h8000;
      2: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  logic [7:0]  ra, rb;
  logic        rc;
  logic [15:0] e_sum;
  logic        e_co, e_ov;
  int          lat;

  initial begin
    rst = 1'b1;
    bus16.start = 0; bus16.a = 0; bus16.b = 0; bus16.cin = 0;
    bus8.start = 0;  bus8.a = 0;  bus8.b = 0;  bus8.cin = 0;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    bus16.sub = 0; bus8.sub = 0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_sum", 32'(bus16.sum), 32'h0);
    chk("rst_busy", 32'(bus16.busy), 32'h0);
    chk("rst_sum8", 32'(bus8.sum), 32'h0);

    go16(16'h00FF, 16'h0001, 1'b0, 1'b0);
    chk("t2_busy_after_accept", 32'(bus16.busy), 32'h1);
    wait16(4);
    chk("t2_sum", 32'(bus16.sum), 32'h0100);
    chk("t2_cout", 32'(bus16.cout), 32'h0);
    @(negedge clk);

    go16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait16(4);
    chk("t3a_sum", 32'(bus16.sum), 32'h0000);
    chk("t3a_cout", 32'(bus16.cout), 32'h1);
    chk("t3a_ovf", 32'(bus16.overflow), 32'h0);
    go16(16'h7FFF, 16'h0000, 1'b1, 1'b0);
    wait16(4);
    chk("t3b_sum", 32'(bus16.sum), 32'h8000);
    chk("t3b_cout", 32'(bus16.cout), 32'h0);
    chk("t3b_ovf", 32'(bus16.overflow), 32'h1);
    @(negedge clk);

    go16(16'h1234, 16'h1111, 1'b0, 1'b1);
    wait16(4);
    chk("t4_sum", 32'(bus16.sum), 32'h2345);
    bus16.a = 16'h0101; bus16.b = 16'h0202; bus16.cin = 1'b0;
    @(negedge clk);
    bus16.start = 1'b0; bus16.a = 16'($urandom); bus16.b = 16'($urandom);
    chk("t4_b2b_busy", 32'(bus16.busy), 32'h1);
    wait16(4);
    chk("t4_b2b_sum", 32'(bus16.sum), 32'h0303);
    @(negedge clk);

    go16(16'h0F0F, 16'h1010, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_abort_sum", 32'(bus16.sum), 32'h0);
    repeat (6) begin
      @(negedge clk);
      chk("t5_no_done", 32'(bus16.done), 32'h0);
    end
    go16(16'h0F0F, 16'h1010, 1'b0, 1'b0);
    wait16(4);
    chk("t5_fresh_sum", 32'(bus16.sum), 32'h1F1F);

`ifdef SEQ_CHUNK_ADDER_SUB_EN
    @(negedge clk);
    bus16.sub = 1'b1;
    go16(16'h0005, 16'h0007, 1'b1, 1'b0);
    bus16.sub = 1'b0;
    wait16(4);
    chk("sub_sum", 32'(bus16.sum), 32'hFFFE);
    chk("sub_cout", 32'(bus16.cout), 32'h0);
    chk("sub_ovf", 32'(bus16.overflow), 32'h0);
`endif

    for (int i = 0; i < 150; i++) begin
`ifdef SEQ_CHUNK_ADDER_SUB_EN
      bus16.sub = 1'($urandom);
`endif
      go16(pick16(), pick16(), 1'($urandom), 1'($urandom_range(0, 3) == 0));
`ifdef SEQ_CHUNK_ADDER_SUB_EN
      bus16.sub = 1'b0;
`endif
      wait16(4);
      bus16.start = 1'b0;
      if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (2) @(negedge clk);

    run8(8'hAA, 8'h55, 1'b1, lat);
    chk("w8_latency", 32'(lat), 32'd8);
    chk("w8_sum", 32'(bus8.sum), 32'h00);
    chk("w8_cout", 32'(bus8.cout), 32'h1);
    chk("w8_ovf", 32'(bus8.overflow), 32'h0);
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      ref_add(8, {8'h00, ra}, {8'h00, rb}, rc, 1'b0, e_sum, e_co, e_ov);
      run8(ra, rb, rc, lat);
      chk("r8_latency", 32'(lat), 32'd8);
      chk("r8_sum", 32'(bus8.sum), 32'(e_sum[7:0]));
      chk("r8_cout", 32'(bus8.cout), 32'(e_co));
      chk("r8_ovf", 32'(bus8.overflow), 32'(e_ov));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
